// File: rtl/icache_set_assoc.sv
// icache_set_assoc: N-way set-associative instruction cache with blocking refill, flush and round-robin victim pointers
// Optional feature: define ICACHE_STATS_EN to add saturating hit/miss counters (stat_hits, stat_misses).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   proc2cache_req/addr            fetch request (level-held) and address
//   flush                          invalidate every line
//   cache2proc_data/valid/busy     returned word, 1-cycle hit pulse, refill in progress
//   cache2mem_addr/command         8-byte aligned refill address, BUS_LOAD while refilling
//   mem2cache_valid/data           refill response pulse and 64-bit line
package icache_set_assoc_pkg;
   typedef enum logic [1:0] {BUS_NONE, BUS_LOAD, BUS_STORE} BUS_COMMAND;
endpackage

module icache_set_assoc
   import icache_set_assoc_pkg::*;
#(
   parameter int NUM_SETS = 16,
   parameter int NUM_WAYS = 2,
   parameter int XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            proc2cache_req,
   input  logic [XLEN-1:0] proc2cache_addr,
   input  logic            flush,
   output logic [XLEN-1:0] cache2proc_data,
   output logic            cache2proc_valid,
   output logic            cache2proc_busy,
   output logic [XLEN-1:0] cache2mem_addr,
   output BUS_COMMAND      cache2mem_command,
`ifdef ICACHE_STATS_EN
   output logic [31:0]     stat_hits,
   output logic [31:0]     stat_misses,
`endif
   input  logic            mem2cache_valid,
   input  logic [63:0]     mem2cache_data
);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int WAY_W = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;
   localparam int TAG_W = XLEN - IDX_W - 3;
   typedef enum logic {IDLE, MISS_WAIT} state_t;
   state_t state;
   logic [NUM_WAYS-1:0] vld [NUM_SETS];
   logic [TAG_W-1:0] tags [NUM_SETS][NUM_WAYS];
   logic [63:0] lines [NUM_SETS][NUM_WAYS];
   logic [WAY_W-1:0] ptr [NUM_SETS];
   logic poison, hit, do_hit, do_miss, fill, unused_bits;
   logic [WAY_W-1:0] hit_way, victim;
   logic [IDX_W-1:0] req_idx, miss_idx;
   logic [TAG_W-1:0] req_tag, miss_tag;
   logic [63:0] hit_line;
   assign req_idx = proc2cache_addr[IDX_W+2:3];
   assign req_tag = proc2cache_addr[XLEN-1:IDX_W+3];
   // the latched refill address doubles as the miss index/tag
   assign miss_idx = cache2mem_addr[IDX_W+2:3];
   assign miss_tag = cache2mem_addr[XLEN-1:IDX_W+3];
   assign hit_line = lines[req_idx][hit_way];
   assign unused_bits = ^proc2cache_addr[1:0];
   // flush suppresses the lookup in the same cycle
   assign do_hit  = state == IDLE && !flush && proc2cache_req && hit;
   assign do_miss = state == IDLE && !flush && proc2cache_req && !hit;
   // a poisoned or flushed-in-flight response is consumed without writing
   assign fill = !rst && state == MISS_WAIT && mem2cache_valid && !flush && !poison;
   // descending scan so the lowest-index invalid way ends up as victim
   always_comb begin
      hit = 1'b0;
      hit_way = '0;
      victim = ptr[miss_idx];
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (vld[req_idx][w] && tags[req_idx][w] == req_tag) begin
            hit = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!vld[miss_idx][w]) victim = WAY_W'(w);
      end
   end
   always_ff @(posedge clk) begin
      if (fill) begin
         lines[miss_idx][victim] <= mem2cache_data;
         tags[miss_idx][victim] <= miss_tag;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         poison <= 1'b0;
         cache2proc_valid <= 1'b0;
         cache2proc_data <= '0;
         cache2proc_busy <= 1'b0;
         cache2mem_command <= BUS_NONE;
         cache2mem_addr <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            vld[s] <= '0;
            ptr[s] <= '0;
         end
      end else begin
         cache2proc_valid <= do_hit;
         if (do_hit) cache2proc_data <= proc2cache_addr[2] ? hit_line[63:32] : hit_line[31:0];
         if (do_miss) begin
            state <= MISS_WAIT;
            poison <= 1'b0;
            cache2proc_busy <= 1'b1;
            cache2mem_command <= BUS_LOAD;
            cache2mem_addr <= {proc2cache_addr[XLEN-1:3], 3'b000};
         end
         if (state == MISS_WAIT && flush) poison <= 1'b1;
         if (state == MISS_WAIT && mem2cache_valid) begin
            state <= IDLE;
            cache2proc_busy <= 1'b0;
            cache2mem_command <= BUS_NONE;
         end
         if (fill) begin
            vld[miss_idx][victim] <= 1'b1;
            ptr[miss_idx] <= ptr[miss_idx] == WAY_W'(NUM_WAYS - 1) ? '0 : ptr[miss_idx] + 1'b1;
         end
         if (flush)
            for (int s = 0; s < NUM_SETS; s++) vld[s] <= '0;
      end
   end
`ifdef ICACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_hits <= '0;
         stat_misses <= '0;
      end else begin
         if (do_hit && stat_hits != '1) stat_hits <= stat_hits + 1'b1;
         if (do_miss && stat_misses != '1) stat_misses <= stat_misses + 1'b1;
      end
   end
`endif
endmodule
